cond_logic: RTL

- Conditional-execution stage of the processor's control unit; sits directly downstream of the control-unit decoder.
- Consumes the decoder's raw write/branch controls, the instruction condition field (Instr[31:28]) and the ALU flags.
- Holds the architectural NZCV flag registers and evaluates the condition against them.
- Squashes PCSrc/RegWrite/MemWrite and the flag update when the condition fails.

---
 rtl/cond_logic.sv | 100 ++++++++++
 1 files changed

// File: rtl/cond_logic.sv
// Conditional-execution stage: evaluates the instruction condition field
// against the registered NZCV flags, gates the decoder's PC/register/memory
// write requests, and updates the flags when the instruction executes.
// Optional statistics counters are built when COND_LOGIC_STATS_EN is defined;
// otherwise exec_cnt and squash_cnt are tied to zero.
module cond_logic #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [3:0] flags_q;
    logic       n_f;
    logic       z_f;
    logic       c_f;
    logic       v_f;
    logic       commit_ex;

    assign flags = flags_q;
    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Condition evaluation uses only the registered flags, so an instruction
    // never sees the flags it is producing itself.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Write requests are squashed combinationally; en only gates state updates.
    assign pc_src    = pcs   & cond_ex;
    assign reg_write = reg_w & cond_ex;
    assign mem_write = mem_w & cond_ex;

    assign commit_ex = en & cond_ex;

    // NZ and CV halves update independently from the ALU flags on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (commit_ex) begin
            if (flag_w[1]) flags_q[3:2] <= alu_flags[3:2];
            if (flag_w[0]) flags_q[1:0] <= alu_flags[1:0];
        end
    end

`ifdef COND_LOGIC_STATS_EN
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] squash_q;

    // Exactly one counter advances per committed instruction; both wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else if (en) begin
            if (cond_ex) exec_q   <= exec_q + 1'b1;
            else         squash_q <= squash_q + 1'b1;
        end
    end

    assign exec_cnt   = exec_q;
    assign squash_cnt = squash_q;
`else
    assign exec_cnt   = '0;
    assign squash_cnt = '0;
`endif

endmodule
